memory_dma_fifo: RTL and testbench

- Device-side byte buffering stage that sits directly below the memory DMA engine. It implements the device modport of if_memory_dma.
- RX path: a byte FIFO accepts bytes from an external producer (USB/UART front end) over valid/ready and exposes them to the DMA engine through rx_empty/rx_almost_empty/rx_read/rx_rdata.
- TX path: a byte FIFO accepts bytes from the DMA engine (or CPU) through tx_write/tx_wdata and drains them to an external consumer over valid/ready.
- Both paths are first-word-fall-through, so read data is valid in the same cycle the read strobe is asserted.

---
 rtl/memory_dma_fifo_if.sv | 58 +++++
 rtl/memory_dma_fifo.sv | 190 +++++++++++++++++++
 tb/tb_memory_dma_fifo.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_dma_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_dma_fifo_if
//  Description : Device-side bus bundle between the memory DMA engine, the
//                external byte producer/consumer and memory_dma_fifo.
//                slave  - the FIFO device (memory_dma_fifo)
//                master - whoever drives producer, DMA and consumer strobes
//  Ports       : RX producer  rx_in_valid/rx_in_ready/rx_in_data
//                RX DMA side  rx_empty/rx_almost_empty/rx_read/rx_rdata
//                TX DMA side  tx_full/tx_almost_full/tx_write/tx_wdata
//                TX consumer  tx_out_valid/tx_out_ready/tx_out_data
//                Control      rx_flush/tx_flush
//                Status       rx_count/tx_count/rx_overflow/tx_underflow
//  Revision    : 1.0 - initial release
// ============================================================================
interface memory_dma_fifo_if #(
   parameter int DEPTH = 1024
);
   localparam int AW = $clog2(DEPTH);

   logic          rx_in_valid;
   logic          rx_in_ready;
   logic [7:0]    rx_in_data;
   logic          rx_empty;
   logic          rx_almost_empty;
   logic          rx_read;
   logic [7:0]    rx_rdata;
   logic          tx_full;
   logic          tx_almost_full;
   logic          tx_write;
   logic [7:0]    tx_wdata;
   logic          tx_out_valid;
   logic          tx_out_ready;
   logic [7:0]    tx_out_data;
   logic          rx_flush;
   logic          tx_flush;
   logic [AW:0]   rx_count;
   logic [AW:0]   tx_count;
   logic          rx_overflow;
   logic          tx_underflow;

   modport slave (
      input  rx_in_valid, rx_in_data, rx_read, tx_write, tx_wdata,
             tx_out_ready, rx_flush, tx_flush,
      output rx_in_ready, rx_empty, rx_almost_empty, rx_rdata, tx_full,
             tx_almost_full, tx_out_valid, tx_out_data, rx_count, tx_count,
             rx_overflow, tx_underflow
   );

   modport master (
      output rx_in_valid, rx_in_data, rx_read, tx_write, tx_wdata,
             tx_out_ready, rx_flush, tx_flush,
      input  rx_in_ready, rx_empty, rx_almost_empty, rx_rdata, tx_full,
             tx_almost_full, tx_out_valid, tx_out_data, rx_count, tx_count,
             rx_overflow, tx_underflow
   );
endinterface
`default_nettype wire

// File: rtl/memory_dma_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : memory_dma_fifo_core
//  Description : First-word-fall-through byte FIFO. Storage is a RAM with a
//                synchronous read port; the read address is looked ahead to
//                the post-edge head so that head data is valid in the cycle
//                after any push/pop, including pops on every cycle.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                flush           - discard contents (wins over push/pop)
//                push, wdata     - write request (dropped while full)
//                pop             - remove head (ignored while empty)
//                head            - oldest entry, don't-care while empty
//                count, empty, almost_empty, full, almost_full - status
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_dma_fifo_core #(
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [7:0]               wdata,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     almost_empty,
   output logic                     full,
   output logic                     almost_full
);
   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_AFULL = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] C_ONE   = (AW+1)'(1);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_empty;
   logic          r_almost_empty;
   logic          r_full;
   logic          r_almost_full;
   logic [7:0]    r_ram_q;
   logic          r_bypass;
   logic [7:0]    r_bypass_data;

   logic          w_push_ok;
   logic          w_pop_ok;
   logic [AW-1:0] w_rd_ptr_nxt;
   logic [AW:0]   w_count_nxt;
   logic          w_bypass_nxt;

   always_comb begin
      w_push_ok    = push && !r_full  && !flush;
      w_pop_ok     = pop  && !r_empty && !flush;
      w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop_ok);
      w_count_nxt  = r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
      // A push that leaves exactly one entry means the byte being written is
      // the new head; the RAM cannot return it yet, so forward it directly.
      w_bypass_nxt = w_push_ok && (w_count_nxt == C_ONE);
   end

   // RAM: no reset so it maps onto block memory
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= wdata;
      end
      r_ram_q <= r_mem[w_rd_ptr_nxt];
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         r_full         <= 1'b0;
         r_almost_full  <= 1'b0;
         r_bypass       <= 1'b0;
         r_bypass_data  <= '0;
      end else begin
         r_wr_ptr       <= r_wr_ptr + AW'(w_push_ok);
         r_rd_ptr       <= w_rd_ptr_nxt;
         r_count        <= w_count_nxt;
         r_empty        <= (w_count_nxt == '0);
         r_almost_empty <= (w_count_nxt <= C_ONE);
         r_full         <= (w_count_nxt == C_FULL);
         r_almost_full  <= (w_count_nxt >= C_AFULL);
         r_bypass       <= w_bypass_nxt;
         r_bypass_data  <= wdata;
      end
   end

   assign head         = r_bypass ? r_bypass_data : r_ram_q;
   assign count        = r_count;
   assign empty        = r_empty;
   assign almost_empty = r_almost_empty;
   assign full         = r_full;
   assign almost_full  = r_almost_full;
endmodule

// ============================================================================
//  Module      : memory_dma_fifo
//  Description : Device-side byte buffer below the memory DMA engine. An RX
//                FIFO carries producer bytes to the DMA, a TX FIFO carries
//                DMA bytes to the consumer. Both are FWFT and independent.
//  Ports       : clk   - system clock
//                reset - synchronous active-high reset
//                bus   - memory_dma_fifo_if.slave (all data/handshake/status)
//  Revision    : 1.0 - initial release
// ============================================================================
module memory_dma_fifo #(
   parameter int DEPTH = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   memory_dma_fifo_if.slave      bus
);
   logic w_rx_full;
   logic w_rx_empty;
   logic w_rx_almost_full;
   logic w_tx_empty;
   logic w_tx_almost_empty;
   logic w_unused_flags;
   logic r_rx_overflow;
   logic r_tx_underflow;

   memory_dma_fifo_core #(.DEPTH(DEPTH)) u_rx (
      .clk          (clk),
      .reset        (reset),
      .flush        (bus.rx_flush),
      .push         (bus.rx_in_valid),
      .wdata        (bus.rx_in_data),
      .pop          (bus.rx_read),
      .head         (bus.rx_rdata),
      .count        (bus.rx_count),
      .empty        (w_rx_empty),
      .almost_empty (bus.rx_almost_empty),
      .full         (w_rx_full),
      .almost_full  (w_rx_almost_full)
   );

   memory_dma_fifo_core #(.DEPTH(DEPTH)) u_tx (
      .clk          (clk),
      .reset        (reset),
      .flush        (bus.tx_flush),
      .push         (bus.tx_write),
      .wdata        (bus.tx_wdata),
      .pop          (bus.tx_out_ready),
      .head         (bus.tx_out_data),
      .count        (bus.tx_count),
      .empty        (w_tx_empty),
      .almost_empty (w_tx_almost_empty),
      .full         (bus.tx_full),
      .almost_full  (bus.tx_almost_full)
   );

   assign w_unused_flags = w_rx_almost_full | w_tx_almost_empty;

   assign bus.rx_in_ready  = !w_rx_full;
   assign bus.rx_empty     = w_rx_empty;
   assign bus.tx_out_valid = !w_tx_empty;

   // tx_underflow reports RX reads while empty (name kept for bus symmetry);
   // it is cleared by tx_flush, overflow by rx_flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_overflow  <= 1'b0;
         r_tx_underflow <= 1'b0;
      end else begin
         if (bus.rx_flush) begin
            r_rx_overflow <= 1'b0;
         end else if (bus.rx_in_valid && w_rx_full) begin
            r_rx_overflow <= 1'b1;
         end
         if (bus.tx_flush) begin
            r_tx_underflow <= 1'b0;
         end else if (bus.rx_read && w_rx_empty) begin
            r_tx_underflow <= 1'b1;
         end
      end
   end

   assign bus.rx_overflow  = r_rx_overflow;
   assign bus.tx_underflow = r_tx_underflow;
endmodule
`default_nettype wire

// File: tb/tb_memory_dma_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_dma_fifo
//  Description : Self-checking bench for memory_dma_fifo. Queue-based
//                reference model, a directed vector table, corner-case
//                sequences and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_dma_fifo;
   localparam int DEPTH = 1024;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   memory_dma_fifo_if #(.DEPTH(DEPTH)) bus ();
   memory_dma_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] rxq[$];
   logic [7:0] txq[$];
   bit         m_ovf;
   bit         m_unf;

   typedef struct {
      logic       valid;
      logic [7:0] data;
      logic       read;
      int         exp_count;
      logic       exp_empty;
      logic       exp_ae;
      logic [7:0] exp_rdata;
      logic       exp_unf;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_update();
      bit rxf, rxe, txf, txe;
      rxf = (rxq.size() == DEPTH);
      rxe = (rxq.size() == 0);
      txf = (txq.size() == DEPTH);
      txe = (txq.size() == 0);
      if (reset) begin
         rxq.delete(); txq.delete(); m_ovf = 0; m_unf = 0;
         return;
      end
      if (bus.rx_in_valid && rxf) m_ovf = 1;
      if (bus.rx_read && rxe)     m_unf = 1;
      if (bus.rx_flush) begin
         rxq.delete(); m_ovf = 0;
      end else begin
         if (bus.rx_read && !rxe)     void'(rxq.pop_front());
         if (bus.rx_in_valid && !rxf) rxq.push_back(bus.rx_in_data);
      end
      if (bus.tx_flush) begin
         txq.delete(); m_unf = 0;
      end else begin
         if (bus.tx_out_ready && !txe) void'(txq.pop_front());
         if (bus.tx_write && !txf)     txq.push_back(bus.tx_wdata);
      end
   endtask

   task automatic compare_all();
      chk("rx_count",        32'(bus.rx_count),   32'(rxq.size()));
      chk("tx_count",        32'(bus.tx_count),   32'(txq.size()));
      chk("rx_empty",        32'(bus.rx_empty),   32'(rxq.size() == 0));
      chk("rx_almost_empty", 32'(bus.rx_almost_empty), 32'(rxq.size() <= 1));
      chk("rx_in_ready",     32'(bus.rx_in_ready), 32'(rxq.size() != DEPTH));
      chk("tx_full",         32'(bus.tx_full),    32'(txq.size() == DEPTH));
      chk("tx_almost_full",  32'(bus.tx_almost_full), 32'(txq.size() >= DEPTH - 1));
      chk("tx_out_valid",    32'(bus.tx_out_valid), 32'(txq.size() != 0));
      chk("rx_overflow",     32'(bus.rx_overflow), 32'(m_ovf));
      chk("tx_underflow",    32'(bus.tx_underflow), 32'(m_unf));
      if (rxq.size() > 0) chk("rx_rdata",    32'(bus.rx_rdata),    32'(rxq[0]));
      if (txq.size() > 0) chk("tx_out_data", 32'(bus.tx_out_data), 32'(txq[0]));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      compare_all();
   endtask

   task automatic idle();
      bus.rx_in_valid  = 0; bus.rx_in_data = '0; bus.rx_read = 0;
      bus.tx_write     = 0; bus.tx_wdata   = '0; bus.tx_out_ready = 0;
      bus.rx_flush     = 0; bus.tx_flush   = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      step();
      reset = 0;
   endtask

   initial begin
      // valid data read | count empty ae rdata unf
      tbl[0] = '{1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b1, 8'h11, 1'b0};
      tbl[1] = '{1'b1, 8'h22, 1'b0, 2, 1'b0, 1'b0, 8'h11, 1'b0};
      tbl[2] = '{1'b1, 8'h33, 1'b0, 3, 1'b0, 1'b0, 8'h11, 1'b0};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 2, 1'b0, 1'b0, 8'h22, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b1, 8'h33, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 8'h00, 1'b0};
      tbl[6] = '{1'b1, 8'h5A, 1'b1, 1, 1'b0, 1'b1, 8'h5A, 1'b1};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b1, 8'h00, 1'b1};

      idle();
      reset = 1;
      step();
      step();
      reset = 0;
      chk("reset_rx_empty", 32'(bus.rx_empty), 32'd1);
      chk("reset_tx_valid", 32'(bus.tx_out_valid), 32'd0);

      // Directed RX vectors
      for (int i = 0; i < 8; i++) begin
         bus.rx_in_valid = tbl[i].valid;
         bus.rx_in_data  = tbl[i].data;
         bus.rx_read     = tbl[i].read;
         step();
         chk($sformatf("tbl%0d_count", i), 32'(bus.rx_count), 32'(tbl[i].exp_count));
         chk($sformatf("tbl%0d_empty", i), 32'(bus.rx_empty), 32'(tbl[i].exp_empty));
         chk($sformatf("tbl%0d_ae", i),    32'(bus.rx_almost_empty), 32'(tbl[i].exp_ae));
         chk($sformatf("tbl%0d_unf", i),   32'(bus.tx_underflow), 32'(tbl[i].exp_unf));
         if (!tbl[i].exp_empty)
            chk($sformatf("tbl%0d_rdata", i), 32'(bus.rx_rdata), 32'(tbl[i].exp_rdata));
      end

      // TX fill to full, extra write dropped, drain in order
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         bus.tx_write = 1;
         bus.tx_wdata = 8'(i % 170);
         step();
         if (i == DEPTH - 2) begin
            chk("fill_af_1023",   32'(bus.tx_almost_full), 32'd1);
            chk("fill_full_1023", 32'(bus.tx_full), 32'd0);
         end
         if (i == DEPTH - 1) chk("fill_full_1024", 32'(bus.tx_full), 32'd1);
      end
      bus.tx_wdata = 8'hAA;
      step();
      chk("extra_write_count", 32'(bus.tx_count), 32'(DEPTH));
      bus.tx_write = 0;
      bus.tx_out_ready = 1;
      for (int i = 0; i < DEPTH; i++) begin
         chk("drain_data", 32'(bus.tx_out_data), 32'(i % 170));
         step();
      end
      chk("drain_count", 32'(bus.tx_count), 32'd0);
      chk("drain_valid", 32'(bus.tx_out_valid), 32'd0);

      // RX steady push+pop across the pointer wrap
      do_reset();
      bus.rx_in_valid = 1;
      bus.rx_read     = 1;
      for (int i = 0; i < DEPTH - 8; i++) begin
         bus.rx_in_data = 8'($urandom);
         step();
      end
      bus.rx_read = 0;
      for (int i = 0; i < 4; i++) begin
         bus.rx_in_data = 8'($urandom);
         step();
      end
      chk("wrap_preload", 32'(bus.rx_count), 32'd5);
      bus.rx_read = 1;
      for (int i = 0; i < 20; i++) begin
         bus.rx_in_data = 8'($urandom);
         step();
         chk("wrap_count", 32'(bus.rx_count), 32'd5);
      end

      // TX flush together with a write
      do_reset();
      bus.tx_write = 1;
      for (int i = 0; i < 10; i++) begin
         bus.tx_wdata = 8'(i + 1);
         step();
      end
      bus.tx_flush = 1;
      bus.tx_wdata = 8'h77;
      step();
      chk("flush_count", 32'(bus.tx_count), 32'd0);
      chk("flush_valid", 32'(bus.tx_out_valid), 32'd0);
      idle();
      step();
      chk("flush_valid_after", 32'(bus.tx_out_valid), 32'd0);

      // Sticky flags, RX full, then reset mid-transfer
      do_reset();
      bus.rx_read = 1;
      step();
      chk("unf_set", 32'(bus.tx_underflow), 32'd1);
      bus.rx_read = 0;
      bus.rx_in_valid = 1;
      for (int i = 0; i < DEPTH; i++) begin
         bus.rx_in_data = 8'(i * 7);
         bus.tx_write   = (i < DEPTH / 2);
         bus.tx_wdata   = 8'(i);
         step();
      end
      bus.tx_write = 0;
      chk("rx_full_ready", 32'(bus.rx_in_ready), 32'd0);
      bus.rx_in_data = 8'hEE;
      step();
      chk("ovf_set", 32'(bus.rx_overflow), 32'd1);
      chk("ovf_count", 32'(bus.rx_count), 32'(DEPTH));
      bus.rx_in_valid = 0;
      bus.rx_read = 1;
      for (int i = 0; i < DEPTH / 2; i++) step();
      bus.rx_read = 0;
      reset = 1;
      step();
      reset = 0;
      chk("rst_rx_count", 32'(bus.rx_count), 32'd0);
      chk("rst_tx_count", 32'(bus.tx_count), 32'd0);
      chk("rst_rx_empty", 32'(bus.rx_empty), 32'd1);
      chk("rst_tx_full",  32'(bus.tx_full), 32'd0);
      chk("rst_ovf",      32'(bus.rx_overflow), 32'd0);
      chk("rst_unf",      32'(bus.tx_underflow), 32'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         bus.rx_in_valid  = 1'($urandom);
         bus.rx_in_data   = 8'($urandom);
         bus.rx_read      = ($urandom_range(0, 2) == 0);
         bus.tx_write     = 1'($urandom);
         bus.tx_wdata     = 8'($urandom);
         bus.tx_out_ready = ($urandom_range(0, 2) == 0);
         bus.rx_flush     = ($urandom_range(0, 63) == 0);
         bus.tx_flush     = ($urandom_range(0, 63) == 0);
         reset            = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 0;
      idle();
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire
